// File: rtl/mem_bus_pkg.sv
// Shared bus types and constants for the mmu request path: arbiter state encoding,
// request field bundle and the address map the mmu decodes.
package mem_bus_pkg;

    localparam int BUS_MEM_W = 32;
    localparam int ADDR_W    = 32;

    localparam logic [ADDR_W-1:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RAM_SIZE   = 32'h0004_0000;
    localparam logic [ADDR_W-1:0] UART_BASE  = 32'hFF00_0000;
    localparam logic [ADDR_W-1:0] TIMER_BASE = 32'hFF00_1000;
    localparam logic [ADDR_W-1:0] MMIO_SIZE  = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic                   we;
        logic [BUS_MEM_W/8-1:0] be;
        logic [BUS_MEM_W-1:0]   wdata;
    } mem_req_t;

    function automatic logic addr_in_region(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single mmu request port between N_REQ masters: round-robin grant, one
// outstanding access, held request fields, optional timeout that turns a hang into an error.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int MEM_W          = BUS_MEM_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*ADDR_W-1:0]    addr_i,
    input  logic [N_REQ-1:0]           we_i,
    input  logic [N_REQ*MEM_W/8-1:0]   be_i,
    input  logic [N_REQ*MEM_W-1:0]     wdata_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           rvalid_o,
    output logic [N_REQ-1:0]           err_o,
    output logic [MEM_W-1:0]           rdata_o,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic                       mem_we_o,
    output logic [MEM_W/8-1:0]         mem_be_o,
    output logic [MEM_W-1:0]           mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic                       mem_err_i,
    input  logic [MEM_W-1:0]           mem_rdata_i,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BE_W  = MEM_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // wait_cnt_reg counts completed WAIT cycles, so the Nth WAIT cycle sees N-1
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [MEM_W-1:0]  wdata;
    } fields_t;

    arb_state_e       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] owner_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    fields_t          fields_reg;
    fields_t          fields_next;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    logic in_issue;
    logic in_wait;
    logic resp_phase;
    logic timeout_hit;
    logic rsp_ok;
    logic rsp_err;
    logic rsp_done;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req   (req_i),
        .ptr   (ptr_reg),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_any)
    );

    always_comb begin
        fields_next.addr  = addr_i[arb_idx*ADDR_W +: ADDR_W];
        fields_next.we    = we_i[arb_idx];
        fields_next.be    = be_i[arb_idx*BE_W +: BE_W];
        fields_next.wdata = wdata_i[arb_idx*MEM_W +: MEM_W];
        ptr_next          = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    assign in_issue    = (state_reg == ISSUE);
    assign in_wait     = (state_reg == WAIT);
    assign resp_phase  = rst && (in_issue || in_wait);
    assign timeout_hit = TO_EN && in_wait && (wait_cnt_reg == TO_LAST);
    // an error outranks a simultaneous rvalid; a real rvalid outranks the timeout
    assign rsp_ok      = resp_phase && mem_rvalid_i && !mem_err_i;
    assign rsp_err     = resp_phase && (mem_err_i || (timeout_hit && !mem_rvalid_i));
    assign rsp_done    = rsp_ok || rsp_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            wait_cnt_reg <= '0;
            fields_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        fields_reg   <= fields_next;
                        owner_reg    <= arb_idx;
                        ptr_reg      <= ptr_next;
                        wait_cnt_reg <= '0;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= rsp_done ? IDLE : WAIT;
                end
                WAIT: begin
                    if (rsp_done) begin
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt_o       = (rst && state_reg == IDLE) ? arb_gnt : '0;
    assign mem_req_o   = rst && in_issue;
    assign mem_addr_o  = rst ? fields_reg.addr  : '0;
    assign mem_we_o    = rst && fields_reg.we;
    assign mem_be_o    = rst ? fields_reg.be    : '0;
    assign mem_wdata_o = rst ? fields_reg.wdata : '0;
    assign busy_o      = rst && (state_reg != IDLE);
    assign owner_o     = rst ? owner_reg : '0;
    assign rdata_o     = rsp_ok ? mem_rdata_i : '0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
        assign rvalid_o[gi] = rsp_ok  && (owner_reg == IDX_W'(gi));
        assign err_o[gi]    = rsp_err && (owner_reg == IDX_W'(gi));
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: dut runs with a long timeout, dut_to with an
// 8-cycle timeout; both see identical stimulus.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_i;
    logic [95:0] addr_i;
    logic [2:0]  we_i;
    logic [11:0] be_i;
    logic [95:0] wdata_i;
    logic        mem_rvalid_i;
    logic        mem_err_i;
    logic [31:0] mem_rdata_i;

    logic [2:0]  gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [3:0]  mem_be_o;
    logic [1:0]  owner_o;

    logic [2:0]  gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
    logic        mem_req_b, mem_we_b, busy_b;
    logic [3:0]  mem_be_b;
    logic [1:0]  owner_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N_REQ(3), .MEM_W(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    mem_bus_arbiter #(.N_REQ(3), .MEM_W(32), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
        .wdata_i(wdata_i), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .err_o(err_b), .rdata_o(rdata_b),
        .mem_req_o(mem_req_b), .mem_addr_o(mem_addr_b), .mem_we_o(mem_we_b), .mem_be_o(mem_be_b),
        .mem_wdata_o(mem_wdata_b), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_b), .owner_o(owner_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_fields(input int i, input logic [31:0] a, input logic w,
                              input logic [3:0] b, input logic [31:0] d);
        addr_i[i*32 +: 32]  = a;
        we_i[i]             = w;
        be_i[i*4 +: 4]      = b;
        wdata_i[i*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        req_i        = 3'b111;
        addr_i       = '0;
        we_i         = '0;
        be_i         = '0;
        wdata_i      = '0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;

        // reset with all requests high: nothing may leak out
        next_cycle();
        next_cycle();
        settle();
        check("rst_gnt", gnt_o, 3'b000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_memreq", mem_req_o, 1'b0);
        check("rst_owner", owner_o, 2'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_rvalid", rvalid_o, 3'b000);

        // single read from requester 0, response in cycle 4
        next_cycle();
        rst   = 1'b1;
        req_i = 3'b001;
        set_fields(0, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
        settle();
        check("t1_gnt", gnt_o, 3'b001);
        check("t1_busy_idle", busy_o, 1'b0);
        next_cycle();
        req_i = 3'b000;
        settle();
        check("t1_memreq", mem_req_o, 1'b1);
        check("t1_addr", mem_addr_o, 32'h0000_1000);
        check("t1_owner", owner_o, 2'd0);
        check("t1_gnt_issue", gnt_o, 3'b000);
        next_cycle();
        settle();
        check("t1_memreq_wait", mem_req_o, 1'b0);
        check("t1_busy_wait", busy_o, 1'b1);
        next_cycle();
        next_cycle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        settle();
        check("t1_rvalid", rvalid_o, 3'b001);
        check("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        check("t1_err", err_o, 3'b000);
        $display("[TB] txn read req0 addr 1000 rdata %0h", rdata_o);
        next_cycle();
        mem_rvalid_i = 1'b0;
        settle();
        check("t1_busy_after", busy_o, 1'b0);
        check("t1_rdata_zero", rdata_o, 32'h0);

        // reset during WAIT: pointer sits at 1, so lone requester 2 wins first
        next_cycle();
        req_i = 3'b100;
        set_fields(2, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
        settle();
        check("t5_gnt", gnt_o, 3'b100);
        next_cycle();
        req_i = 3'b000;
        next_cycle();
        settle();
        check("t5_busy_wait", busy_o, 1'b1);
        check("t5_owner", owner_o, 2'd2);
        next_cycle();
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        settle();
        check("t5_rvalid_in_rst", rvalid_o, 3'b000);
        check("t5_busy_in_rst", busy_o, 1'b0);
        check("t5_addr_in_rst", mem_addr_o, 32'h0);
        check("t5_rdata_in_rst", rdata_o, 32'h0);
        next_cycle();
        req_i = 3'b111;
        settle();
        check("t5_gnt_in_rst", gnt_o, 3'b000);
        check("t5_rvalid_after", rvalid_o, 3'b000);
        $display("[TB] txn req2 abandoned by reset");

        // round robin with 0-wait responses; mem_rvalid_i stays high so IDLE sees strays
        next_cycle();
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [2:0] exp_oh;
            exp_oh = 3'b001 << (t % 3);
            settle();
            check($sformatf("t2_gnt_%0d", t), gnt_o, exp_oh);
            check($sformatf("t2_stray_%0d", t), rvalid_o, 3'b000);
            next_cycle();
            mem_rdata_i = 32'hA000_0000 + t;
            settle();
            check($sformatf("t2_gnt_gap_%0d", t), gnt_o, 3'b000);
            check($sformatf("t2_rvalid_%0d", t), rvalid_o, exp_oh);
            check($sformatf("t2_rdata_%0d", t), rdata_o, 32'hA000_0000 + t);
            $display("[TB] txn rr #%0d owner %0d rdata %0h", t, owner_o, rdata_o);
            next_cycle();
            if (t == 5) begin
                req_i        = 3'b000;
                mem_rvalid_i = 1'b0;
            end
        end
        settle();
        check("t2_busy_end", busy_o, 1'b0);

        // write from requester 2 answered with error (and rvalid) in WAIT
        next_cycle();
        req_i = 3'b100;
        set_fields(2, 32'h0000_0050, 1'b1, 4'hF, 32'h1234_5678);
        settle();
        check("t3_gnt", gnt_o, 3'b100);
        next_cycle();
        req_i = 3'b000;
        settle();
        check("t3_we", mem_we_o, 1'b1);
        check("t3_addr", mem_addr_o, 32'h0000_0050);
        check("t3_wdata", mem_wdata_o, 32'h1234_5678);
        next_cycle();
        mem_err_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        settle();
        check("t3_err", err_o, 3'b100);
        check("t3_rvalid", rvalid_o, 3'b000);
        check("t3_rdata", rdata_o, 32'h0);
        $display("[TB] txn write req2 addr 50 err %b", err_o);
        next_cycle();
        mem_err_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        settle();
        check("t3_busy_after", busy_o, 1'b0);
        check("t3_err_after", err_o, 3'b000);

        // timeout: requester 1, mmu silent; dut_to errors on its 8th WAIT cycle
        next_cycle();
        req_i = 3'b010;
        set_fields(1, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
        settle();
        check("t4_gnt", gnt_b, 3'b010);
        next_cycle();
        req_i = 3'b000;
        settle();
        check("t4_memreq", mem_req_b, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            settle();
            check($sformatf("t4_err_w%0d", k), err_b, (k == 8) ? 3'b010 : 3'b000);
        end
        check("t4_rvalid_to", rvalid_b, 3'b000);
        check("t4_long_no_err", err_o, 3'b000);
        $display("[TB] txn req1 timeout err %b", err_b);
        next_cycle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55AA_55AA;
        settle();
        check("t4_busy_after", busy_b, 1'b0);
        check("t4_late_rvalid", rvalid_b, 3'b000);
        check("t4_late_err", err_b, 3'b000);
        check("t4_long_rvalid", rvalid_o, 3'b010);
        next_cycle();
        mem_rvalid_i = 1'b0;
        settle();
        check("t4_long_busy", busy_o, 1'b0);

        // stability: inputs scrambled after grant, response 20 cycles after grant
        next_cycle();
        req_i = 3'b001;
        set_fields(0, 32'hA5A5_0000, 1'b1, 4'b0110, 32'hCAFE_F00D);
        settle();
        check("t6_gnt", gnt_o, 3'b001);
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 1) begin
                req_i = 3'b000;
                set_fields(0, 32'h5A5A_FFFF, 1'b0, 4'b1001, 32'h0BAD_0BAD);
            end
            if (c == 20) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h600D_600D;
            end
            settle();
            check($sformatf("t6_memreq_%0d", c), mem_req_o, (c == 1) ? 1'b1 : 1'b0);
            check($sformatf("t6_fields_%0d", c), {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                  {32'hA5A5_0000, 1'b1, 4'b0110, 32'hCAFE_F00D});
        end
        check("t6_rvalid", rvalid_o, 3'b001);
        check("t6_rdata", rdata_o, 32'h600D_600D);
        check("t6_to_stray", rvalid_b, 3'b000);
        $display("[TB] txn write req0 addr a5a50000 held 20 cycles");
        next_cycle();
        mem_rvalid_i = 1'b0;
        settle();
        check("t6_busy_after", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
